neuron_sum_ctrl: RTL and testbench
==================================

NEURON_SUM_CTRL -- requirements
Module: neuron_sum_ctrl

Interface
REQ-001 The block SHALL have parameter BIAS_EN, default 1; when 1, the bias feeds summer slot 32; when 0, slot 32 is forced to 0.0.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-006 The block SHALL have port in_data, input, real: one weighted neuron input per beat.
REQ-007 The block SHALL have port in_last, input, 1 bit: marks the final beat of a frame.
REQ-008 The block SHALL have port bias, input, real: sampled on the first accepted beat of each frame.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_sum and out_err are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port out_sum, output, real: registered 33-term sum.
REQ-012 The block SHALL have port out_err, output, 1 bit: the frame length was not 32.
REQ-013 The block SHALL have port busy, output, 1 bit: state is not IDLE.

Function
REQ-014 A beat SHALL be accepted exactly when in_valid and in_ready are both 1 at a rising clk edge.
REQ-015 The block SHALL implement the states IDLE, LOAD, SUM and HOLD.
REQ-016 In IDLE, in_ready SHALL be 1; the first accepted beat SHALL write buf[0], latch bias, set cnt=1 and move to LOAD.
REQ-017 In LOAD, in_ready SHALL be 1; each accepted beat SHALL write buf[cnt] and increment the 5-bit cnt.
REQ-018 When beat 32 (cnt=31) is accepted with in_last=1, the block SHALL move to SUM.
REQ-019 If in_last=1 arrives at cnt<31, the block SHALL clear buf, set err_q=1 and move to SUM.
REQ-020 If cnt=31 is accepted with in_last=0, the block SHALL set err_q=1, move to SUM, and stay in IDLE-drop mode, ignoring further beats through the next in_last.
REQ-021 In SUM, in_ready SHALL be 0; out_sum SHALL register the sum from summer (buf[0..31] plus bias slot), or 0.0 if err_q is set; out_err SHALL register err_q; the next state SHALL be HOLD.
REQ-022 Latency: last beat accepted at edge k means out_valid=1 after edge k+2.
REQ-023 In HOLD, out_valid SHALL be 1 and in_ready SHALL be 0; out_sum and out_err SHALL be held stable until out_ready=1.
REQ-024 When out_valid and out_ready are both 1 at an edge, the block SHALL clear out_valid, err_q and cnt and return to IDLE; no input beat is accepted in that same cycle.
REQ-025 A single-beat frame (in_last on beat 1) SHALL be treated as an error per REQ-019.
REQ-026 Gaps in in_valid during LOAD SHALL NOT alter cnt or buf.
REQ-027 Summation order SHALL be the fixed pairwise tree of summer.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, cnt=0, err_q=0, buf[*]=0.0, bias_q=0.0, out_sum=0.0, out_err=0, out_valid=0, in_ready=0 and busy=0.
REQ-029 After rst_n deasserts, in_ready SHALL rise after the first clk edge.
REQ-030 Reset mid-frame SHALL discard all partial data, and the block SHALL produce no result for that frame.

Structure
REQ-031 A shared package neuron_pkg SHALL hold N_IN=32, the state enum type and the cnt width.
REQ-032 The block SHALL contain exactly one sub-module instance, the existing summer (33 real inputs to 1 real sum), fed combinationally from buf and bias_q.

Verification
REQ-033 32 beats of 1.0 with in_last on beat 32 and bias=0.5 -> out_sum=32.5, out_err=0, out_valid 2 cycles after the last beat.
REQ-034 Beats i=0..31 with value i, bias=-496.0 and BIAS_EN=0 -> out_sum=496.0.
REQ-035 in_last on beat 5 -> out_valid with out_err=1 and out_sum=0.0; the next 32-beat frame sums correctly.
REQ-036 out_ready held 0 for 10 cycles in HOLD -> out_sum stable, in_ready=0 throughout; it is released on the first out_ready=1.
REQ-037 rst_n pulsed low after beat 17 -> all outputs zero immediately; the following full frame of 2.0 values with bias 0 -> out_sum=64.0.
REQ-038 Random in_valid gaps across a full frame of 0.25 values -> out_sum=8.0 plus bias.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared constants and FSM state type for the neuron summing controller.
package neuron_pkg;

    localparam int unsigned N_IN    = 32;
    localparam int unsigned N_TERMS = N_IN + 1;
    localparam int unsigned CNT_W   = 5;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SUM  = 2'd2,
        HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/neuron_sum_ctrl_summer.sv
// Fixed-order adder: balanced pairwise tree over the 32 inputs, then the bias slot.
module summer
    import neuron_pkg::*;
(
    input  real terms [N_TERMS],
    output real sum
);

    real lvl [N_IN];

    always_comb begin
        for (int unsigned i = 0; i < N_IN; i++) begin
            lvl[i] = terms[i];
        end
        // In-place reduction; ascending i never reads an already-overwritten slot.
        for (int unsigned w = N_IN / 2; w > 0; w = w / 2) begin
            for (int unsigned i = 0; i < w; i++) begin
                lvl[i] = lvl[2*i] + lvl[2*i+1];
            end
        end
        sum = lvl[0] + terms[N_IN];
    end

endmodule

// File: rtl/neuron_sum_ctrl.sv
// Collects 32 weighted inputs plus bias per frame and presents their registered sum
// with a valid/ready handshake; malformed frames report out_err with a zero sum.
module neuron_sum_ctrl
    import neuron_pkg::*;
#(
    parameter bit BIAS_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  real  in_data,
    input  logic in_last,
    input  real  bias,
    output logic out_valid,
    input  logic out_ready,
    output real  out_sum,
    output logic out_err,
    output logic busy
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             drop_q;
    logic             ready_en_q;
    logic             sum_stage_q;
    real              buf_q [N_IN];
    real              bias_q;
    real              sum_pipe_q;
    real              out_sum_q;
    logic             out_err_q;

    real              terms [N_TERMS];
    real              tree_sum;
    logic             accept;

    assign in_ready  = ready_en_q && ((state_q == IDLE) || (state_q == LOAD));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign out_sum   = out_sum_q;
    assign out_err   = out_err_q;

    always_comb begin
        for (int unsigned i = 0; i < N_IN; i++) begin
            terms[i] = buf_q[i];
        end
        terms[N_IN] = BIAS_EN ? bias_q : 0.0;
    end

    summer u_summer (
        .terms (terms),
        .sum   (tree_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept && !drop_q) begin
                    state_d = in_last ? SUM : LOAD;
                end
            end
            LOAD: begin
                if (accept && (in_last || (cnt_q == CNT_LAST))) begin
                    state_d = SUM;
                end
            end
            SUM: begin
                if (sum_stage_q) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            err_q       <= 1'b0;
            drop_q      <= 1'b0;
            ready_en_q  <= 1'b0;
            sum_stage_q <= 1'b0;
            bias_q      <= 0.0;
            sum_pipe_q  <= 0.0;
            out_sum_q   <= 0.0;
            out_err_q   <= 1'b0;
            for (int unsigned i = 0; i < N_IN; i++) begin
                buf_q[i] <= 0.0;
            end
        end else begin
            ready_en_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (drop_q) begin
                            if (in_last) begin
                                drop_q <= 1'b0;
                            end
                        end else begin
                            bias_q <= bias;
                            if (in_last) begin
                                err_q <= 1'b1;
                                for (int unsigned i = 0; i < N_IN; i++) begin
                                    buf_q[i] <= 0.0;
                                end
                            end else begin
                                buf_q[0] <= in_data;
                                cnt_q    <= CNT_W'(1);
                            end
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (in_last && (cnt_q != CNT_LAST)) begin
                            err_q <= 1'b1;
                            for (int unsigned i = 0; i < N_IN; i++) begin
                                buf_q[i] <= 0.0;
                            end
                        end else begin
                            buf_q[cnt_q] <= in_data;
                            if (cnt_q == CNT_LAST) begin
                                if (!in_last) begin
                                    err_q  <= 1'b1;
                                    drop_q <= 1'b1;
                                end
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end
                // SUM spends two cycles: the tree result is captured first, then
                // transferred to the output register, giving last-beat-to-valid of 2 edges.
                SUM: begin
                    if (!sum_stage_q) begin
                        sum_stage_q <= 1'b1;
                        sum_pipe_q  <= err_q ? 0.0 : tree_sum;
                    end else begin
                        sum_stage_q <= 1'b0;
                        out_sum_q   <= sum_pipe_q;
                        out_err_q   <= err_q;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        err_q <= 1'b0;
                        cnt_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_sum_ctrl.sv
// Directed bench: two instances (bias enabled / disabled) share one input stream.
module tb_neuron_sum_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic in_last;
    logic out_ready;
    real  in_data;
    real  bias;

    logic in_ready, out_valid, out_err, busy;
    real  out_sum;
    logic nb_in_ready, nb_out_valid, nb_out_err, nb_busy;
    real  nb_out_sum;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    neuron_sum_ctrl #(.BIAS_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_err   (out_err),
        .busy      (busy)
    );

    neuron_sum_ctrl #(.BIAS_EN(1'b0)) dut_nb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (nb_in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .bias      (bias),
        .out_valid (nb_out_valid),
        .out_ready (out_ready),
        .out_sum   (nb_out_sum),
        .out_err   (nb_out_err),
        .busy      (nb_busy)
    );

    task automatic check(input string tag, input real act, input real exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %f expected %f", tag, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic drive_beat(input real d, input logic last, input real b);
        logic took;
        int   n = 0;
        in_data  = d;
        in_last  = last;
        bias     = b;
        in_valid = 1'b1;
        forever begin
            took = in_ready;
            @(negedge clk);
            if (took) break;
            n++;
            if (n > 100) begin
                check("beat_accept_timeout", 0.0, 1.0);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input int last_at, input real base,
                              input real step, input real b, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                for (int g = 0; g < (i * 7) % 3; g++) @(negedge clk);
            end
            drive_beat(base + step * i, (i == last_at), b);
        end
    endtask

    // Entered at the negedge after the last accepted beat (edge k).
    task automatic check_latency(input string tag);
        check({tag, "_busy_sum"}, real'(busy), 1.0);
        check({tag, "_v_k"}, real'(out_valid), 0.0);
        @(negedge clk);
        check({tag, "_v_k1"}, real'(out_valid), 0.0);
        @(negedge clk);
        check({tag, "_v_k2"}, real'(out_valid), 1.0);
    endtask

    task automatic take_result(input string tag, input real exp_sum,
                               input real exp_nb, input logic exp_err);
        check({tag, "_sum"}, out_sum, exp_sum);
        check({tag, "_sum_nb"}, nb_out_sum, exp_nb);
        check({tag, "_err"}, real'(out_err), real'(exp_err));
        check({tag, "_rdy_hold"}, real'(in_ready), 0.0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_v_clr"}, real'(out_valid), 0.0);
        check({tag, "_rdy_idle"}, real'(in_ready), 1.0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        in_data   = 0.0;
        bias      = 0.0;
        #1;
        check("rst_valid", real'(out_valid), 0.0);
        check("rst_ready", real'(in_ready), 0.0);
        check("rst_busy", real'(busy), 0.0);
        check("rst_sum", out_sum, 0.0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready0", real'(in_ready), 0.0);
        @(negedge clk);
        check("post_rst_ready1", real'(in_ready), 1.0);

        // 32 x 1.0, bias 0.5
        send_frame(32, 31, 1.0, 0.0, 0.5, 1'b0);
        check_latency("f1");
        take_result("f1", 32.5, 32.0, 1'b0);

        // ramp 0..31, bias -496
        send_frame(32, 31, 0.0, 1.0, -496.0, 1'b0);
        check_latency("f2");
        take_result("f2", 0.0, 496.0, 1'b0);

        // short frame, then a good frame
        send_frame(5, 4, 7.0, 1.0, 3.0, 1'b0);
        check_latency("short");
        take_result("short", 0.0, 0.0, 1'b1);
        send_frame(32, 31, 3.0, 0.0, 1.0, 1'b0);
        check_latency("f3");
        take_result("f3", 97.0, 96.0, 1'b0);

        // single-beat frame
        send_frame(1, 0, 9.0, 0.0, 1.0, 1'b0);
        check_latency("single");
        take_result("single", 0.0, 0.0, 1'b1);

        // back-pressure in HOLD with a beat pending
        send_frame(32, 31, 0.5, 0.0, 2.0, 1'b0);
        check_latency("bp");
        in_valid = 1'b1;
        in_data  = 50.0;
        for (int c = 0; c < 10; c++) begin
            check("bp_sum_stable", out_sum, 18.0);
            check("bp_ready_low", real'(in_ready), 0.0);
            check("bp_valid_high", real'(out_valid), 1.0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        take_result("bp", 18.0, 16.0, 1'b0);

        // reset after beat 17
        send_frame(17, -1, 1.0, 0.0, 4.0, 1'b0);
        check("mid_busy", real'(busy), 1.0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sum", out_sum, 0.0);
        check("mid_rst_valid", real'(out_valid), 0.0);
        check("mid_rst_ready", real'(in_ready), 0.0);
        check("mid_rst_busy", real'(busy), 0.0);
        check("mid_rst_err", real'(out_err), 0.0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_no_result", real'(out_valid), 0.0);
        send_frame(32, 31, 2.0, 0.0, 0.0, 1'b0);
        check_latency("f4");
        take_result("f4", 64.0, 64.0, 1'b0);

        // in_valid gaps
        send_frame(32, 31, 0.25, 0.0, 1.5, 1'b1);
        check_latency("gap");
        take_result("gap", 9.5, 8.0, 1'b0);

        // overflow, then drop beats through the next in_last
        send_frame(32, -1, 1.0, 0.0, 0.0, 1'b0);
        check_latency("ovf");
        take_result("ovf", 0.0, 0.0, 1'b1);
        send_frame(3, 2, 100.0, 0.0, 100.0, 1'b0);
        @(negedge clk);
        check("drop_busy", real'(busy), 0.0);
        check("drop_valid", real'(out_valid), 0.0);
        send_frame(32, 31, 1.0, 0.0, 0.0, 1'b0);
        check_latency("f5");
        take_result("f5", 32.0, 32.0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
